ysyx_22040365_wb_ctrl: RTL and testbench
========================================

# ysyx_22040365_wb_ctrl

Write-back controller for the NPC integer register file. Arbitrates the single register-file write port between the execute unit (EXU) and the load/store unit (LSU) with round-robin fairness. Registers the winning write onto the port. Keeps a per-register pending-write scoreboard so the issue stage can detect RAW/WAW hazards on rs1/rs2/rd.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; register count NREG = 1<<ADDR_WIDTH
- DATA_WIDTH, 64, register data width

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- exu_valid  in  1  EXU has a result to write
- exu_ready  out  1  EXU result accepted this cycle
- exu_rd  in  ADDR_WIDTH  EXU destination register
- exu_data  in  DATA_WIDTH  EXU result
- lsu_valid  in  1  LSU has load data to write
- lsu_ready  out  1  LSU result accepted this cycle
- lsu_rd  in  ADDR_WIDTH  LSU destination register
- lsu_data  in  DATA_WIDTH  LSU load data
- iss_valid  in  1  issue stage dispatches an instruction writing iss_rd
- iss_rd  in  ADDR_WIDTH  destination of dispatched instruction
- rs1, rs2  in  ADDR_WIDTH each  source registers being checked
- rs1_busy, rs2_busy, rd_busy  out  1 each  pending write on rs1/rs2/iss_rd
- rf_wen  out  1  register-file write enable
- rf_waddr  out  ADDR_WIDTH  register-file write address
- rf_wdata  out  DATA_WIDTH  register-file write data

## Operation
- Transfer on a requester = valid & ready in the same cycle.
- Priority pointer `prio` ∈ {LSU, EXU}, reset to LSU.
- exu_ready = !rst & (!lsu_valid | prio==EXU); lsu_ready = !rst & (!exu_valid | prio==LSU). Both valid → exactly one ready. Ready never depends on the requester's own valid.
- After any transfer, prio points to the other requester. With no transfer, prio holds.
- Output stage is always drainable, so no back-pressure beyond arbitration.
- rd==0 transfer: the handshake completes, rf_wen stays 0 next cycle, and no scoreboard change occurs.
- Scoreboard: NREG bits, bit 0 hard-wired 0.
  - Set: iss_valid & iss_rd!=0.
  - Clear: rf_wen & rf_waddr in the registered write cycle.
  - Same bit set and cleared in the same cycle: set wins.
- Busy outputs are combinational reads of the scoreboard: rs1_busy = sb[rs1], rs2_busy = sb[rs2], rd_busy = sb[iss_rd].
- Issue protocol: the issuer must not assert iss_valid while rd_busy=1. Setting an already-set bit leaves it at 1 and fires a simulation assertion.

## Timing
- Reset values:
  - rf_wen=0, rf_waddr=0, rf_wdata=0
  - scoreboard all 0, prio=LSU
  - exu_ready=lsu_ready=0 while rst=1
- Latency:
  - Transfer in cycle N → rf_wen=1 with rf_waddr/rf_wdata in cycle N+1.
  - The register file captures at the end of N+1.
  - The scoreboard bit clears at the same edge, so busy=0 from N+2, when the register file already holds the value.
- No transfer in cycle N → rf_wen=0 in N+1; rf_waddr/rf_wdata hold their last values.
- Throughput: one write per cycle sustained; alternating EXU/LSU under continuous contention.
- Reset mid-operation: a transfer accepted in the cycle rst rises is dropped (rf_wen=0 after reset), and pending scoreboard bits are cleared.
- iss_valid in cycle N → busy visible from N+1.

## Structure
- Shared package `ysyx_22040365_pkg` holds:
  - ADDR_WIDTH/DATA_WIDTH defaults
  - requester-id enum (REQ_LSU=0, REQ_EXU=1)
- Sub-module `ysyx_22040365_scoreboard`:
  - NREG-bit set/clear vector with three combinational lookup ports
  - instantiated once
- Arbiter, prio register and output register live in the top.

## Test plan
- Reset, then EXU-only request rd=5, data=0x1234 → exu_ready=1 in N; rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in N+1; rf_wen=0 in N+2.
- Both valid continuously for 4 cycles from reset (EXU rd=1, LSU rd=2) → grant order LSU, EXU, LSU, EXU; rf_waddr sequence 2,1,2,1.
- iss_valid, iss_rd=7 in cycle 0, then EXU transfer rd=7 in cycle 3 → rs1=7 gives rs1_busy=1 in cycles 1..4 and 0 from cycle 5.
- EXU transfer rd=0, data=0xFFFF → exu_ready=1; rf_wen stays 0; rs1=0 gives rs1_busy=0 throughout.
- Issue rd=9, then in the cycle rf_wen=1/rf_waddr=9 assert iss_valid, iss_rd=9 → bit 9 remains 1 (set wins) and the assertion fires.
- LSU transfer in cycle N with rst=1 in N+1 → rf_wen=0 in N+1 and N+2; all busy outputs 0; prio=LSU afterwards.

Source files
------------

// File: rtl/ysyx_22040365_pkg.sv
// Shared definitions for the NPC write-back controller: default widths and
// the requester identifiers used by the round-robin arbiter.
package ysyx_22040365_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 64;

    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_EXU = 1'b1
    } req_e;

endpackage

// File: rtl/ysyx_22040365_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction writing that register issues and cleared when its write-back
// reaches the register file. Register 0 never reports a pending write.
module ysyx_22040365_scoreboard
    import ysyx_22040365_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en_i,
    input  logic [ADDR_WIDTH-1:0] set_idx_i,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_idx_i,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rd_busy_o
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // Next-state: clear first so a same-cycle set on the same bit wins.
    always_comb begin
        sb_d = sb_q;
        if (clr_en_i) begin
            sb_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i && (set_idx_i != '0)) begin
            sb_d[set_idx_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Flag an issue to a register whose previous write is still in flight.
    always_ff @(posedge clk) begin
        if (!rst && set_en_i && (set_idx_i != '0)) begin
            assert (!sb_q[set_idx_i])
                else $warning("scoreboard: issue to already-pending register %0d", set_idx_i);
        end
    end

    assign rs1_busy_o = sb_q[rs1_i];
    assign rs2_busy_o = sb_q[rs2_i];
    assign rd_busy_o  = sb_q[rd_i];

endmodule

// File: rtl/ysyx_22040365_wb_ctrl.sv
// Write-back controller: round-robin arbitration of the single register-file
// write port between EXU and LSU, a registered write stage, and the pending
// write scoreboard used by issue for RAW/WAW hazard detection.
module ysyx_22040365_wb_ctrl
    import ysyx_22040365_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    req_e                  prio_q;
    req_e                  prio_d;
    logic                  exu_xfer;
    logic                  lsu_xfer;
    logic                  wen_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;

    // Ready depends only on the other requester and the pointer, never on
    // the requester's own valid, so there is no valid->ready loop.
    assign exu_ready = !rst && (!lsu_valid || (prio_q == REQ_EXU));
    assign lsu_ready = !rst && (!exu_valid || (prio_q == REQ_LSU));
    assign exu_xfer  = exu_valid && exu_ready;
    assign lsu_xfer  = lsu_valid && lsu_ready;

    // Arbitration: pick the winner's payload and hand priority to the loser.
    always_comb begin
        prio_d  = prio_q;
        wen_d   = 1'b0;
        waddr_d = rf_waddr_q;
        wdata_d = rf_wdata_q;
        if (exu_xfer) begin
            prio_d = REQ_LSU;
            if (exu_rd != '0) begin
                wen_d   = 1'b1;
                waddr_d = exu_rd;
                wdata_d = exu_data;
            end
        end else if (lsu_xfer) begin
            prio_d = REQ_EXU;
            if (lsu_rd != '0) begin
                wen_d   = 1'b1;
                waddr_d = lsu_rd;
                wdata_d = lsu_data;
            end
        end
    end

    // Priority pointer and registered write-port stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= REQ_LSU;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            prio_q     <= prio_d;
            rf_wen_q   <= wen_d;
            rf_waddr_q <= waddr_d;
            rf_wdata_q <= wdata_d;
        end
    end

    // A write registered just before reset rises is dropped, not committed.
    assign rf_wen   = rf_wen_q && !rst;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    ysyx_22040365_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (iss_valid),
        .set_idx_i  (iss_rd),
        .clr_en_i   (rf_wen),
        .clr_idx_i  (rf_waddr),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rd_i       (iss_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy)
    );

endmodule

// File: tb/tb_ysyx_22040365_wb_ctrl.sv
// Directed bench for the write-back controller.
module tb_ysyx_22040365_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22040365_wb_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_busy   (rd_busy),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next cycle; inputs are driven 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        exu_valid = 1'b1; lsu_valid = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen got %0h want 0", rf_wen); end
        n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr got %0h want 0", rf_waddr); end
        n_checks++; if (rf_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_rf_wdata got %0h want 0", rf_wdata); end
        n_checks++; if (exu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_exu_ready got %0h want 0", exu_ready); end
        n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lsu_ready got %0h want 0", lsu_ready); end
        n_checks++; if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_busy got %b want 000", {rs1_busy, rs2_busy, rd_busy}); end
        next_cycle();
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_exu_single();
        do_reset();
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'h1234;
        #1;
        n_checks++; if (exu_ready !== 1'b1) begin n_fail++; $display("FAIL exu_single_ready got %0h want 1", exu_ready); end
        next_cycle();
        exu_valid = 1'b0;
        #1;
        n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL exu_single_wen got %0h want 1", rf_wen); end
        n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL exu_single_waddr got %0h want 5", rf_waddr); end
        n_checks++; if (rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL exu_single_wdata got %0h want 1234", rf_wdata); end
        next_cycle();
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL exu_single_wen_after got %0h want 0", rf_wen); end
        n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL exu_single_waddr_hold got %0h want 5", rf_waddr); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_addr [4];
        exp_addr[0] = 5'd2; exp_addr[1] = 5'd1; exp_addr[2] = 5'd2; exp_addr[3] = 5'd1;
        do_reset();
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 64'hE1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 64'h52;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (lsu_ready !== ((k % 2) == 0)) begin n_fail++; $display("FAIL b2b_lsu_ready[%0d] got %0h want %0h", k, lsu_ready, (k % 2) == 0); end
            n_checks++; if (exu_ready !== ((k % 2) == 1)) begin n_fail++; $display("FAIL b2b_exu_ready[%0d] got %0h want %0h", k, exu_ready, (k % 2) == 1); end
            next_cycle();
            n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== exp_addr[k]) begin n_fail++; $display("FAIL b2b_write[%0d] got wen=%0h addr=%0d want wen=1 addr=%0d", k, rf_wen, rf_waddr, exp_addr[k]); end
            n_checks++; if (rf_wdata !== ((k % 2 == 0) ? 64'h52 : 64'hE1)) begin n_fail++; $display("FAIL b2b_wdata[%0d] got %0h", k, rf_wdata); end
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard_raw();
        do_reset();
        // cycle 0: issue rd=7
        iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
        #1;
        n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL raw_busy_c0 got %0h want 0", rs1_busy); end
        next_cycle();
        iss_valid = 1'b0;
        #1;
        n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL raw_busy_c1 got %0h want 1", rs1_busy); end
        next_cycle();
        n_checks++; if (rs2_busy !== 1'b1 || rd_busy !== 1'b1) begin n_fail++; $display("FAIL raw_busy_c2 got rs2=%0h rd=%0h want 1 1", rs2_busy, rd_busy); end
        next_cycle();
        // cycle 3: EXU writes rd=7
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 64'h77;
        #1;
        n_checks++; if (rs1_busy !== 1'b1 || exu_ready !== 1'b1) begin n_fail++; $display("FAIL raw_c3 got busy=%0h ready=%0h want 1 1", rs1_busy, exu_ready); end
        next_cycle();
        exu_valid = 1'b0;
        #1;
        n_checks++; if (rs1_busy !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin n_fail++; $display("FAIL raw_c4 got busy=%0h wen=%0h addr=%0d want 1 1 7", rs1_busy, rf_wen, rf_waddr); end
        next_cycle();
        n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL raw_c5 got rs1=%0h rs2=%0h want 0 0", rs1_busy, rs2_busy); end
    endtask

    task automatic test_rd_zero();
        idle_inputs();
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'hFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        #1;
        n_checks++; if (exu_ready !== 1'b1 || rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rd0_c0 got ready=%0h busy=%0h want 1 0", exu_ready, rs1_busy); end
        next_cycle();
        exu_valid = 1'b0; iss_valid = 1'b0;
        #1;
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rd0_wen got %0h want 0", rf_wen); end
        n_checks++; if (rs1_busy !== 1'b0 || rd_busy !== 1'b0) begin n_fail++; $display("FAIL rd0_busy got rs1=%0h rd=%0h want 0 0", rs1_busy, rd_busy); end
        n_checks++; if (rf_waddr !== 5'd7 || rf_wdata !== 64'h77) begin n_fail++; $display("FAIL rd0_hold got addr=%0d data=%0h want 7 77", rf_waddr, rf_wdata); end
        next_cycle();
        n_checks++; if (rf_wen !== 1'b0 || rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rd0_c2 got wen=%0h busy=%0h want 0 0", rf_wen, rs1_busy); end
    endtask

    task automatic test_set_wins();
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd9;
        next_cycle();
        iss_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 64'h99;
        next_cycle();
        exu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        #1;
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9) begin n_fail++; $display("FAIL setwins_write got wen=%0h addr=%0d want 1 9", rf_wen, rf_waddr); end
        next_cycle();
        iss_valid = 1'b0; rs1 = 5'd9;
        #1;
        n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL setwins_bit9 got %0h want 1", rs1_busy); end
        next_cycle();
        n_checks++; if (rs1_busy !== 1'b1 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL setwins_hold got busy=%0h wen=%0h want 1 0", rs1_busy, rf_wen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        // cycle N: LSU transfer rd=3, issue rd=4
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'hAB;
        iss_valid = 1'b1; iss_rd = 5'd4;
        #1;
        n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %0h want 1", lsu_ready); end
        next_cycle();
        // cycle N+1: reset rises
        lsu_valid = 1'b0; iss_valid = 1'b0; rst = 1'b1;
        #1;
        n_checks++; if (rf_wen !== 1'b0 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_n1 got wen=%0h ready=%0h want 0 0", rf_wen, lsu_ready); end
        next_cycle();
        rst = 1'b0;
        rs1 = 5'd4; rs2 = 5'd3; iss_rd = 5'd4;
        exu_valid = 1'b1; exu_rd = 5'd1; lsu_valid = 1'b1; lsu_rd = 5'd2;
        #1;
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_n2_wen got %0h want 0", rf_wen); end
        n_checks++; if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_busy got %b want 000", {rs1_busy, rs2_busy, rd_busy}); end
        n_checks++; if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_prio got lsu=%0h exu=%0h want 1 0", lsu_ready, exu_ready); end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_exu_single();
        test_back_to_back();
        test_scoreboard_raw();
        test_rd_zero();
        test_set_wins();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
